axis_pow_checker: RTL

- AXI-Stream slave stage directly downstream of the power-of-MULT sequence generator.
- Buffers incoming beats in a small FIFO and forwards them unchanged on an AXI-Stream master port.
- Checks each accepted beat against the expected geometric sequence, and keeps match/error statistics and a sticky error flag for software and the bench.

---
 rtl/axis_lab_pkg.sv | 16 +
 rtl/axis_fifo_fwft.sv | 63 ++++++
 rtl/axis_pow_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/axis_lab_pkg.sv
// Shared constants and checker state encodings for the AXI-Stream lab blocks.
// The sequence constants are shared with the power-of-MULT generator so both
// ends of the stream agree on what the sequence looks like.
package axis_lab_pkg;

   localparam int DEFAULT_DATA_SIZE = 32;
   localparam int SEQ_MULT          = 3;
   localparam int SEQ_INIT_EXPECT   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ERROR = 2'd2
   } checkState_t;

endpackage

// File: rtl/axis_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is always visible on popData,
// so the consumer sees a beat on the cycle right after it was written.
// Push is refused while full even if a pop happens in the same cycle.
module axis_fifo_fwft #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 4,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int COUNT_W = PTR_W + 1
) (
   input  logic               clock,
   input  logic               resetN,
   input  logic               pushValid,
   input  logic [WIDTH-1:0]   pushData,
   input  logic               popReady,
   output logic [WIDTH-1:0]   popData,
   output logic               full,
   output logic               empty,
   output logic [COUNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic             pushEn;
   logic             popEn;

   assign full    = (count == COUNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pushEn  = pushValid && !full;
   assign popEn   = popReady && !empty;
   assign popData = mem[rdPtr];

   // Storage array has no reset: stale entries are never visible because the
   // occupancy count gates everything the consumer is allowed to look at.
   always_ff @(posedge clock) begin
      if (pushEn) begin
         mem[wrPtr] <= pushData;
      end
   end

   // Pointer and occupancy bookkeeping. Depth is a power of two, so the
   // pointers simply wrap. A simultaneous push and pop leaves the count as is.
   always_ff @(posedge clock) begin
      if (!resetN) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (pushEn) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (popEn) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({pushEn, popEn})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis_pow_checker.sv
// AXI-Stream pass-through stage that sits behind the power-of-MULT generator.
// Beats are buffered in a small FWFT FIFO and forwarded untouched, while every
// accepted beat is compared on the input side against the expected geometric
// sequence to maintain match/error statistics and a sticky error indication.
module axis_pow_checker
   import axis_lab_pkg::*;
#(
   parameter int DATA_SIZE   = DEFAULT_DATA_SIZE,
   parameter int MULT        = SEQ_MULT,
   parameter int INIT_EXPECT = SEQ_INIT_EXPECT,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic                   s00_axis_aclk,
   input  logic                   s00_axis_aresetn,
   input  logic                   check_enable,
   input  logic [DATA_SIZE-1:0]   s00_axis_tdata,
   input  logic [DATA_SIZE/8-1:0] s00_axis_tstrb,
   input  logic                   s00_axis_tvalid,
   output logic                   s00_axis_tready,
   input  logic                   s00_axis_tlast,
   output logic [DATA_SIZE-1:0]   m00_axis_tdata,
   output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
   output logic                   m00_axis_tvalid,
   input  logic                   m00_axis_tready,
   output logic                   m00_axis_tlast,
   output logic [CNT_W-1:0]       match_count,
   output logic [CNT_W-1:0]       error_count,
   output logic                   error_flag,
   output logic [1:0]             state_o
);

   localparam int STRB_W  = DATA_SIZE / 8;
   localparam int FIFO_W  = DATA_SIZE + STRB_W + 1;
   localparam int COUNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DATA_SIZE-1:0] MULT_V = DATA_SIZE'(MULT);
   localparam logic [DATA_SIZE-1:0] INIT_V = DATA_SIZE'(INIT_EXPECT);

   logic [FIFO_W-1:0]    fifoIn;
   logic [FIFO_W-1:0]    fifoOut;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [COUNT_W-1:0]   fifoCount;
   logic                 acceptBeat;
   logic                 checkBeat;
   logic                 isMatch;
   logic [DATA_SIZE-1:0] product;
   logic [DATA_SIZE-1:0] expected;
   logic [DATA_SIZE-1:0] expectedNext;
   logic [CNT_W-1:0]     matchNext;
   logic [CNT_W-1:0]     errorNext;
   logic                 flagNext;
   checkState_t          state;
   checkState_t          stateNext;

   assign s00_axis_tready = !fifoFull;
   assign acceptBeat      = s00_axis_tvalid && s00_axis_tready;
   assign checkBeat       = acceptBeat && check_enable;
   assign isMatch         = (s00_axis_tdata == expected);
   assign product         = s00_axis_tdata * MULT_V;
   assign fifoIn          = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};

   assign m00_axis_tvalid = (fifoCount != '0);
   assign {m00_axis_tlast, m00_axis_tstrb, m00_axis_tdata} = fifoEmpty ? '0 : fifoOut;
   assign state_o         = state;

   axis_fifo_fwft #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (s00_axis_aclk),
      .resetN    (s00_axis_aresetn),
      .pushValid (s00_axis_tvalid),
      .pushData  (fifoIn),
      .popReady  (m00_axis_tready),
      .popData   (fifoOut),
      .full      (fifoFull),
      .empty     (fifoEmpty),
      .count     (fifoCount)
   );

   // Next-state logic for the checker. Everything holds unless a beat is
   // accepted while checking is enabled. A mismatch resynchronises on the
   // received value, but a frame end always reloads the initial expectation.
   // Counters saturate at all-ones instead of wrapping. ERROR is absorbing.
   always_comb begin
      stateNext    = state;
      expectedNext = expected;
      matchNext    = match_count;
      errorNext    = error_count;
      flagNext     = error_flag;
      if (checkBeat) begin
         if (isMatch) begin
            matchNext = (match_count == '1) ? match_count : match_count + 1'b1;
         end else begin
            errorNext = (error_count == '1) ? error_count : error_count + 1'b1;
            flagNext  = 1'b1;
         end
         expectedNext = s00_axis_tlast ? INIT_V : product;
         case (state)
            ST_IDLE: begin
               if (!isMatch) begin
                  stateNext = ST_ERROR;
               end else if (!s00_axis_tlast) begin
                  stateNext = ST_RUN;
               end
            end
            ST_RUN: begin
               if (!isMatch) begin
                  stateNext = ST_ERROR;
               end else if (s00_axis_tlast) begin
                  stateNext = ST_IDLE;
               end
            end
            default: stateNext = ST_ERROR;
         endcase
      end
   end

   // Checker registers with synchronous active-low reset; the FIFO clears on
   // the same reset so buffered beats are dropped together with the statistics.
   always_ff @(posedge s00_axis_aclk) begin
      if (!s00_axis_aresetn) begin
         state       <= ST_IDLE;
         expected    <= INIT_V;
         match_count <= '0;
         error_count <= '0;
         error_flag  <= 1'b0;
      end else begin
         state       <= stateNext;
         expected    <= expectedNext;
         match_count <= matchNext;
         error_count <= errorNext;
         error_flag  <= flagNext;
      end
   end

endmodule
